// File: rtl/rom_read_port.sv
// -----------------------------------------------------------------------------
// rom_read_port
//
// Handshaked, byte-serial read port in front of a single-byte-wide ROM array.
// A request (byte / halfword / word at any byte address) is accepted in IDLE.
// The bytes are then fetched one per cycle from mem[] and assembled
// little-endian. The result is sign- or zero-extended and held on the
// response channel until the consumer takes it.
// Malformed sizes and out-of-range accesses answer immediately with
// resp_error=1 and resp_data=0.
//
// Ports
//   clk          : clock, all state changes on the rising edge
//   reset_n      : asynchronous active-low reset
//   req_valid    : request present
//   req_ready    : block can accept a request (high only in IDLE)
//   req_address  : byte address of the least significant byte
//   req_size     : 0 = byte, 1 = halfword, 2 = word, 3 = reserved (error)
//   req_unsigned : 1 = zero-extend, 0 = sign-extend from the top fetched byte
//   resp_valid   : response present (high only in DONE)
//   resp_ready   : consumer accepts the response
//   resp_data    : extended read result, 0 on error
//   resp_error   : request was illegal
// -----------------------------------------------------------------------------
module rom_read_port #(
   parameter int    ROM_SIZE   = 4096,
   parameter string INIT_FILE  = "../main/riscv_cpu.mif",
   parameter int    ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_address,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [31:0]           resp_data,
   output logic                  resp_error
);

   localparam int IDX_W = (ROM_SIZE > 4) ? $clog2(ROM_SIZE) : 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // ROM contents. The FPGA tools load INIT_FILE into the array.
   // Simulation benches preload mem hierarchically.
   (* ram_init_file = INIT_FILE *) logic [7:0] mem [0:ROM_SIZE-1];

   state_t           r_state;
   state_t           w_state_next;

   logic [IDX_W-1:0] r_idx;
   logic [1:0]       r_size;
   logic             r_unsigned;
   logic [1:0]       r_cnt;
   logic [31:0]      r_asm;
   logic [31:0]      r_data;
   logic             r_err;

   logic             w_accept;
   logic [2:0]       w_req_nbm1;
   logic [ADDR_WIDTH:0] w_req_last;
   logic             w_range_err;
   logic             w_req_err;
   logic [1:0]       w_cnt_last;
   logic             w_last_byte;
   logic [IDX_W-1:0] w_rd_idx;
   logic [7:0]       w_byte;
   logic [31:0]      w_asm_next;
   logic [31:0]      w_ext;

   // ---------------------------------------------------------------- request
   assign w_accept = (r_state == ST_IDLE) && req_valid;

   // nbytes-1 for the incoming request. Reserved size 3 is flagged separately,
   // so its value here is irrelevant.
   always_comb begin
      w_req_nbm1 = 3'd0;
      case (req_size)
         2'd1:    w_req_nbm1 = 3'd1;
         2'd2:    w_req_nbm1 = 3'd3;
         default: w_req_nbm1 = 3'd0;
      endcase
   end

   // Last byte address computed one bit wider than the address.
   // An access that wraps past the top of the address space therefore
   // also lands above ROM_SIZE.
   assign w_req_last  = {1'b0, req_address} + (ADDR_WIDTH+1)'(w_req_nbm1);
   assign w_range_err = (w_req_last >= (ADDR_WIDTH+1)'(ROM_SIZE));
   assign w_req_err   = (req_size == 2'd3) || w_range_err;

   // ---------------------------------------------------------------- fetch
   // Legal accesses stay below ROM_SIZE, so only the low index bits of the
   // address need to be kept.
   assign w_rd_idx = r_idx + IDX_W'(r_cnt);
   assign w_byte   = mem[w_rd_idx];

   always_comb begin
      w_cnt_last = 2'd0;
      case (r_size)
         2'd1:    w_cnt_last = 2'd1;
         2'd2:    w_cnt_last = 2'd3;
         default: w_cnt_last = 2'd0;
      endcase
   end

   assign w_last_byte = (r_cnt == w_cnt_last);

   always_comb begin
      w_asm_next = r_asm;
      w_asm_next[r_cnt*8 +: 8] = w_byte;
   end

   // Extend from the byte that is being fetched now. On the last READ
   // cycle that is the top byte of the access.
   always_comb begin
      w_ext = w_asm_next;
      case (r_size)
         2'd0:    w_ext = {{24{~r_unsigned & w_asm_next[7]}},  w_asm_next[7:0]};
         2'd1:    w_ext = {{16{~r_unsigned & w_asm_next[15]}}, w_asm_next[15:0]};
         default: w_ext = w_asm_next;
      endcase
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (req_valid) begin
               w_state_next = w_req_err ? ST_DONE : ST_READ;
            end
         end
         ST_READ: begin
            if (w_last_byte) begin
               w_state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            if (resp_ready) begin
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_idx      <= '0;
         r_size     <= 2'd0;
         r_unsigned <= 1'b0;
         r_cnt      <= 2'd0;
         r_asm      <= 32'd0;
         r_data     <= 32'd0;
         r_err      <= 1'b0;
      end else if (w_accept) begin
         r_idx      <= req_address[IDX_W-1:0];
         r_size     <= req_size;
         r_unsigned <= req_unsigned;
         r_cnt      <= 2'd0;
         r_asm      <= 32'd0;
         r_data     <= 32'd0;
         r_err      <= w_req_err;
      end else if (r_state == ST_READ) begin
         r_asm <= w_asm_next;
         r_cnt <= r_cnt + 2'd1;
         if (w_last_byte) begin
            r_data <= w_ext;
         end
      end
   end

   // ---------------------------------------------------------------- outputs
   assign req_ready  = (r_state == ST_IDLE);
   assign resp_valid = (r_state == ST_DONE);
   assign resp_data  = r_data;
   assign resp_error = r_err;

endmodule

// File: tb/tb_rom_read_port.sv
// -----------------------------------------------------------------------------
// tb_rom_read_port
//
// Self-checking bench for rom_read_port with ROM_SIZE=4096. The ROM is
// preloaded with random bytes plus a few fixed bytes at 0x10..0x13. Responses
// are compared against a reference model that works from the ROM contents and
// the access rules directly: range arithmetic, little-endian sum, extension.
// -----------------------------------------------------------------------------
module tb_rom_read_port;

   localparam int ROM_SZ = 4096;

   logic        clk;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_address;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_data;
   logic        resp_error;

   logic [7:0]  model_mem [0:ROM_SZ-1];

   int n_checks = 0;
   int n_errors = 0;

   rom_read_port #(
      .ROM_SIZE   (ROM_SZ),
      .INIT_FILE  ("none.mif"),
      .ADDR_WIDTH (32)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_address  (req_address),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_data    (resp_data),
      .resp_error   (resp_error)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model. Returns {error, data}.
   function automatic logic [32:0] model(input logic [31:0] a, input logic [1:0] s, input logic u);
      longint unsigned la;
      longint unsigned v;
      int n;
      if (s == 2'd3) return {1'b1, 32'd0};
      n  = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
      la = {32'd0, a};
      if (la + longint'(n) - 1 >= longint'(ROM_SZ)) return {1'b1, 32'd0};
      v = 0;
      for (int i = 0; i < n; i++) begin
         v = v + (longint'(model_mem[int'(la) + i]) << (8 * i));
      end
      if (!u && v >= (64'd1 << (8 * n - 1))) begin
         v = v + (64'd1 << 32) - (64'd1 << (8 * n));
      end
      return {1'b0, v[31:0]};
   endfunction

   function automatic int exp_latency(input logic [32:0] m, input logic [1:0] s);
      if (m[32]) return 1;
      return (s == 2'd0) ? 2 : (s == 2'd1) ? 3 : 5;
   endfunction

   // Drives one request from a sample point with the DUT idle. It returns when
   // resp_valid is seen, or after a bounded wait. The request inputs are
   // scrambled right after acceptance, so an in-flight access must ignore them.
   task automatic issue(input logic [31:0] a, input logic [1:0] s, input logic u,
                        output int lat, output logic [31:0] d, output logic e);
      req_address  = a;
      req_size     = s;
      req_unsigned = u;
      req_valid    = 1'b1;
      @(posedge clk); #1;
      req_valid    = 1'b0;
      req_address  = $urandom;
      req_size     = 2'($urandom_range(3, 0));
      req_unsigned = 1'($urandom_range(1, 0));
      lat = 1;
      while (resp_valid !== 1'b1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      d = resp_data;
      e = resp_error;
   endtask

   task automatic retire();
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      n_checks++;
      if (req_ready !== 1'b1) begin n_errors++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
      n_checks++;
      if (resp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid); end
      n_checks++;
      if (resp_data !== 32'd0) begin n_errors++; $display("FAIL reset_resp_data got=%h want=0", resp_data); end
      n_checks++;
      if (resp_error !== 1'b0) begin n_errors++; $display("FAIL reset_resp_error got=%b want=0", resp_error); end
      $display("reset: req_ready=%b resp_valid=%b resp_data=%h resp_error=%b",
               req_ready, resp_valid, resp_data, resp_error);
   endtask

   task automatic test_directed();
      logic [31:0] a_tab [4] = '{32'h10, 32'h12, 32'h12, 32'h11};
      logic [1:0]  s_tab [4] = '{2'd2, 2'd0, 2'd0, 2'd1};
      logic        u_tab [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      logic [31:0] d_tab [4] = '{32'h44832211, 32'hFFFFFF83, 32'h00000083, 32'hFFFF8322};
      int          l_tab [4] = '{5, 2, 2, 3};
      int lat; logic [31:0] d; logic e;
      for (int i = 0; i < 4; i++) begin
         issue(a_tab[i], s_tab[i], u_tab[i], lat, d, e);
         $display("directed: addr=%h size=%0d uns=%b data=%h err=%b lat=%0d",
                  a_tab[i], s_tab[i], u_tab[i], d, e, lat);
         n_checks++;
         if (d !== d_tab[i]) begin n_errors++; $display("FAIL directed_data[%0d] got=%h want=%h", i, d, d_tab[i]); end
         n_checks++;
         if (e !== 1'b0) begin n_errors++; $display("FAIL directed_err[%0d] got=%b want=0", i, e); end
         n_checks++;
         if (lat !== l_tab[i]) begin n_errors++; $display("FAIL directed_latency[%0d] got=%0d want=%0d", i, lat, l_tab[i]); end
         retire();
      end
   endtask

   task automatic test_boundary();
      logic [31:0] a_tab [4] = '{32'hFFC, 32'hFFD, 32'hFFFFFFFE, 32'h0};
      logic [1:0]  s_tab [4] = '{2'd2, 2'd2, 2'd2, 2'd3};
      logic        e_tab [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
      int lat; logic [31:0] d; logic e; logic [32:0] m;
      for (int i = 0; i < 4; i++) begin
         m = model(a_tab[i], s_tab[i], 1'b0);
         issue(a_tab[i], s_tab[i], 1'b0, lat, d, e);
         $display("boundary: addr=%h size=%0d data=%h err=%b lat=%0d", a_tab[i], s_tab[i], d, e, lat);
         n_checks++;
         if (e !== e_tab[i]) begin n_errors++; $display("FAIL boundary_err[%0d] got=%b want=%b", i, e, e_tab[i]); end
         n_checks++;
         if (d !== m[31:0]) begin n_errors++; $display("FAIL boundary_data[%0d] got=%h want=%h", i, d, m[31:0]); end
         n_checks++;
         if (lat !== (e_tab[i] ? 1 : 5)) begin n_errors++; $display("FAIL boundary_latency[%0d] got=%0d want=%0d", i, lat, e_tab[i] ? 1 : 5); end
         retire();
      end
   endtask

   task automatic test_random();
      int lat; logic [31:0] d; logic e; logic [32:0] m;
      logic [31:0] a; logic [1:0] s; logic u;
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(2, 0))
            0:       a = $urandom_range(ROM_SZ - 1, 0);
            1:       a = $urandom_range(ROM_SZ - 1, ROM_SZ - 8);
            default: a = $urandom;
         endcase
         s = 2'($urandom_range(3, 0));
         u = 1'($urandom_range(1, 0));
         m = model(a, s, u);
         issue(a, s, u, lat, d, e);
         $display("random: addr=%h size=%0d uns=%b data=%h err=%b lat=%0d", a, s, u, d, e, lat);
         n_checks++;
         if ({e, d} !== m) begin n_errors++; $display("FAIL random_resp[%0d] got=%b/%h want=%b/%h", i, e, d, m[32], m[31:0]); end
         n_checks++;
         if (lat !== exp_latency(m, s)) begin n_errors++; $display("FAIL random_latency[%0d] got=%0d want=%0d", i, lat, exp_latency(m, s)); end
         retire();
      end
   endtask

   task automatic test_backpressure();
      int lat; logic [31:0] d; logic e; logic [32:0] m;
      logic [31:0] a;
      a = $urandom_range(ROM_SZ - 4, 0);
      m = model(a, 2'd2, 1'b0);
      issue(a, 2'd2, 1'b0, lat, d, e);
      $display("backpressure: addr=%h data=%h err=%b lat=%0d", a, d, e, lat);
      n_checks++;
      if ({e, d} !== m) begin n_errors++; $display("FAIL bp_resp got=%b/%h want=%b/%h", e, d, m[32], m[31:0]); end
      for (int c = 0; c < 10; c++) begin
         req_address = $urandom;
         @(posedge clk); #1;
         n_checks++;
         if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_data !== m[31:0] || resp_error !== m[32]) begin
            n_errors++;
            $display("FAIL bp_hold[%0d] got valid=%b ready=%b data=%h err=%b want 1/0/%h/%b",
                     c, resp_valid, req_ready, resp_data, resp_error, m[31:0], m[32]);
         end
      end
      retire();
      n_checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL bp_release got valid=%b ready=%b want 0/1", resp_valid, req_ready);
      end
      a = $urandom_range(ROM_SZ - 2, 0);
      m = model(a, 2'd1, 1'b1);
      issue(a, 2'd1, 1'b1, lat, d, e);
      $display("backpressure_next: addr=%h data=%h err=%b lat=%0d", a, d, e, lat);
      n_checks++;
      if ({e, d} !== m || lat !== 3) begin
         n_errors++;
         $display("FAIL bp_next got=%b/%h lat=%0d want=%b/%h lat=3", e, d, lat, m[32], m[31:0]);
      end
      retire();
   endtask

   task automatic test_back_to_back();
      logic [32:0] exp_q [$];
      logic [32:0] m;
      int last_t = -1;
      int n_resp = 0;
      resp_ready = 1'b1;
      for (int cyc = 0; cyc < 80; cyc++) begin
         if (resp_valid === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_errors++;
               $display("FAIL b2b_unexpected got=%h at cycle %0d", resp_data, cyc);
            end else begin
               m = exp_q.pop_front();
               if ({resp_error, resp_data} !== m) begin
                  n_errors++;
                  $display("FAIL b2b_resp[%0d] got=%b/%h want=%b/%h", n_resp, resp_error, resp_data, m[32], m[31:0]);
               end
            end
            $display("b2b: resp %0d data=%h err=%b cycle=%0d", n_resp, resp_data, resp_error, cyc);
            if (last_t >= 0) begin
               n_checks++;
               if (cyc - last_t !== 6) begin
                  n_errors++;
                  $display("FAIL b2b_interval[%0d] got=%0d want=6", n_resp, cyc - last_t);
               end
            end
            last_t = cyc;
            n_resp++;
         end
         if (req_ready === 1'b1 && cyc < 60) begin
            req_address  = $urandom_range(ROM_SZ - 4, 0);
            req_size     = 2'd2;
            req_unsigned = 1'($urandom_range(1, 0));
            req_valid    = 1'b1;
            exp_q.push_back(model(req_address, req_size, req_unsigned));
         end else if (req_ready === 1'b1) begin
            req_valid = 1'b0;
         end
         @(posedge clk); #1;
      end
      req_valid  = 1'b0;
      resp_ready = 1'b0;
      n_checks++;
      if (exp_q.size() != 0 || n_resp < 9) begin
         n_errors++;
         $display("FAIL b2b_drain got pending=%0d responses=%0d want 0 pending, >=9 responses", exp_q.size(), n_resp);
      end
   endtask

   task automatic test_reset_mid_read();
      int lat; logic [31:0] d; logic e;
      req_address  = 32'h10;
      req_size     = 2'd2;
      req_unsigned = 1'b0;
      req_valid    = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      #2 reset_n = 1'b0;
      #1;
      n_checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL midreset_state got valid=%b ready=%b want 0/1", resp_valid, req_ready);
      end
      n_checks++;
      if (resp_data !== 32'd0 || resp_error !== 1'b0) begin
         n_errors++;
         $display("FAIL midreset_outputs got data=%h err=%b want 0/0", resp_data, resp_error);
      end
      $display("midreset: valid=%b ready=%b data=%h", resp_valid, req_ready, resp_data);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      issue(32'h10, 2'd0, 1'b1, lat, d, e);
      $display("after_reset: addr=00000010 size=0 data=%h err=%b lat=%0d", d, e, lat);
      n_checks++;
      if (d !== 32'h00000011 || e !== 1'b0 || lat !== 2) begin
         n_errors++;
         $display("FAIL after_reset_read got=%h err=%b lat=%0d want=00000011 err=0 lat=2", d, e, lat);
      end
      retire();
   endtask

   initial begin
      reset_n      = 1'b0;
      req_valid    = 1'b0;
      req_address  = 32'd0;
      req_size     = 2'd0;
      req_unsigned = 1'b0;
      resp_ready   = 1'b0;
      for (int i = 0; i < ROM_SZ; i++) begin
         model_mem[i] = 8'($urandom_range(255, 0));
      end
      model_mem[16'h10] = 8'h11;
      model_mem[16'h11] = 8'h22;
      model_mem[16'h12] = 8'h83;
      model_mem[16'h13] = 8'h44;
      for (int i = 0; i < ROM_SZ; i++) begin
         dut.mem[i] = model_mem[i];
      end
      #1;
      @(posedge clk); #1;
      test_reset();
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      test_directed();
      test_boundary();
      test_backpressure();
      test_random();
      test_back_to_back();
      test_reset_mid_read();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
